// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bundle: the pipeline (master) issues read/write requests and
// the responder (slave) returns read data, a stall while busy and a one-cycle completion.
interface data_mem_responder_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_ack;
  logic        addr_err;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout,
    input  mem_din, mem_stall, mem_ack, addr_err
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout,
    output mem_din, mem_stall, mem_ack, addr_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM answering MEM-stage requests; ack WAIT_STATES+1 cycles after request.
// Holds the pipeline via mem_stall until the ack cycle; dropping the request mid-wait aborts it.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LP_WAIT     = 4'(WAIT_STATES);
  localparam bit         LP_HAS_WAIT = (WAIT_STATES > 0);

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic                    r_wr;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_err;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [2**ADDR_WIDTH];

  logic                    w_req;
  logic                    w_start;
  logic                    w_commit;
  logic                    w_c_wr;
  logic [31:0]             w_c_addr;
  logic [31:0]             w_c_data;
  logic                    w_bad;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_ack;
  logic                    w_stall;
  logic                    w_err;

  assign w_req   = bus.mem_ren | bus.mem_wen;
  assign w_start = (r_state == S_IDLE) && w_req;

  // With zero wait states the commit edge is the request edge, so use the live inputs.
  assign w_c_wr   = (r_state == S_IDLE) ? bus.mem_wen  : r_wr;
  assign w_c_addr = (r_state == S_IDLE) ? bus.mem_addr : r_addr;
  assign w_c_data = (r_state == S_IDLE) ? bus.mem_dout : r_wdata;

  assign w_bad    = (w_c_addr[1:0] != 2'b00) || ((w_c_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign w_idx    = w_c_addr[ADDR_WIDTH+1:2];
  assign w_commit = rst_n && (w_next == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = LP_HAS_WAIT ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack   = (r_state == S_DONE);
    w_stall = rst_n && w_req && (r_state != S_DONE);
    w_err   = w_ack && r_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_start) begin
      r_cnt   <= LP_WAIT;
      r_wr    <= bus.mem_wen;
      r_addr  <= bus.mem_addr;
      r_wdata <= bus.mem_dout;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Writes and faulted accesses return zero on mem_din.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_bad;
      r_rdata <= (w_c_wr || w_bad) ? 32'd0 : r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_c_wr && !w_bad) begin
      r_mem[w_idx] <= w_c_data;
    end
  end

  assign bus.mem_din   = r_rdata;
  assign bus.mem_stall = w_stall;
  assign bus.mem_ack   = w_ack;
  assign bus.addr_err  = w_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: dut_a runs with 2 wait states, dut_b with none.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder_if bus_a();
  data_mem_responder_if bus_b();

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  task automatic drive(input bit sel, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      bus_b.mem_ren = ren; bus_b.mem_wen = wen; bus_b.mem_addr = addr; bus_b.mem_dout = data;
    end else begin
      bus_a.mem_ren = ren; bus_a.mem_wen = wen; bus_a.mem_addr = addr; bus_a.mem_dout = data;
    end
  endtask

  // Runs one access; reports ack latency in cycles (-1 if none), the ack-cycle outputs,
  // and whether stall was high before the ack and low in the ack cycle.
  task automatic access(input bit sel, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output logic err, output logic [31:0] din,
                        output bit stall_ok, output int ack_cyc);
    logic ack, stall;
    lat = -1; err = 1'bx; din = 'x; stall_ok = 1'b1; ack_cyc = -1;
    @(negedge clk);
    drive(sel, ren, wen, addr, data);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ack   = sel ? bus_b.mem_ack   : bus_a.mem_ack;
      stall = sel ? bus_b.mem_stall : bus_a.mem_stall;
      if (ack === 1'b1) begin
        lat     = c;
        err     = sel ? bus_b.addr_err : bus_a.addr_err;
        din     = sel ? bus_b.mem_din  : bus_a.mem_din;
        ack_cyc = cyc;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus_a.mem_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", bus_a.mem_stall); end
    n_cmp++; if (bus_a.mem_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", bus_a.mem_ack); end
    n_cmp++; if (bus_a.addr_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus_a.addr_err); end
    n_cmp++; if (bus_a.mem_din !== 32'h0) begin n_bad++; $display("FAIL rst_din_a: got %h want 0", bus_a.mem_din); end
    n_cmp++; if (bus_b.mem_din !== 32'h0) begin n_bad++; $display("FAIL rst_din_b: got %h want 0", bus_b.mem_din); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat, ac; logic err; logic [31:0] din; bit sok;
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, lat, err, din, sok, ac);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_lat: got %0d want 3", lat); end
    n_cmp++; if (sok !== 1'b1) begin n_bad++; $display("FAIL wr_stall: got %b want 1", sok); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", err); end
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_lat: got %0d want 3", lat); end
    n_cmp++; if (din !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_din: got %h want 12345678", din); end
    n_cmp++; if (sok !== 1'b1) begin n_bad++; $display("FAIL rd_stall: got %b want 1", sok); end
  endtask

  task automatic test_misaligned();
    int lat, ac; logic err; logic [31:0] din; bit sok;
    access(1'b0, 1'b0, 1'b1, 32'h13, 32'hDEAD_BEEF, lat, err, din, sok, ac);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mis_lat: got %0d want 3", lat); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", err); end
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (din !== 32'h1234_5678) begin n_bad++; $display("FAIL mis_keep: got %h want 12345678", din); end
  endtask

  task automatic test_out_of_range();
    int lat, ac; logic err; logic [31:0] din; bit sok;
    access(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b want 1", err); end
    n_cmp++; if (din !== 32'h0) begin n_bad++; $display("FAIL oor_din: got %h want 0", din); end
    access(1'b0, 1'b0, 1'b1, 32'h0FFC, 32'hCAFE_0001, lat, err, din, sok, ac);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL top_wr_err: got %b want 0", err); end
    access(1'b0, 1'b1, 1'b0, 32'h0FFC, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL top_rd_err: got %b want 0", err); end
    n_cmp++; if (din !== 32'hCAFE_0001) begin n_bad++; $display("FAIL top_rd_din: got %h want cafe0001", din); end
  endtask

  task automatic test_flush();
    int lat, ac; logic err; logic [31:0] din; bit sok; bit seen_ack;
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111_2222, lat, err, din, sok, ac);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hAAAA_5555);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    seen_ack = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (bus_a.mem_ack === 1'b1) seen_ack = 1'b1;
    end
    n_cmp++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL flush_ack: got %b want 0", seen_ack); end
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (din !== 32'h1111_2222) begin n_bad++; $display("FAIL flush_keep: got %h want 11112222", din); end
  endtask

  task automatic test_reset_mid();
    int lat, ac; logic err; logic [31:0] din; bit sok;
    access(1'b0, 1'b0, 1'b1, 32'h24, 32'h3333_4444, lat, err, din, sok, ac);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (din !== 32'h1234_5678) begin n_bad++; $display("FAIL pre_rst_din: got %h want 12345678", din); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h24, 32'h5555_6666);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_a.mem_stall !== 1'b0) begin n_bad++; $display("FAIL mrst_stall_now: got %b want 0", bus_a.mem_stall); end
    @(negedge clk); #1;
    n_cmp++; if (bus_a.mem_ack !== 1'b0) begin n_bad++; $display("FAIL mrst_ack: got %b want 0", bus_a.mem_ack); end
    n_cmp++; if (bus_a.mem_din !== 32'h0) begin n_bad++; $display("FAIL mrst_din: got %h want 0", bus_a.mem_din); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (din !== 32'h3333_4444) begin n_bad++; $display("FAIL mrst_keep: got %h want 33334444", din); end
  endtask

  task automatic test_ws0();
    int lat, ac; logic err; logic [31:0] din; bit sok;
    access(1'b1, 1'b0, 1'b1, 32'h30, 32'h0000_0001, lat, err, din, sok, ac);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ws0_lat: got %0d want 1", lat); end
    n_cmp++; if (sok !== 1'b1) begin n_bad++; $display("FAIL ws0_stall: got %b want 1", sok); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ws0_err: got %b want 0", err); end
    access(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (din !== 32'h0000_0001) begin n_bad++; $display("FAIL ws0_rd1: got %h want 00000001", din); end
    access(1'b1, 1'b1, 1'b1, 32'h30, 32'h0000_0002, lat, err, din, sok, ac);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL both_lat: got %0d want 1", lat); end
    n_cmp++; if (din !== 32'h0) begin n_bad++; $display("FAIL both_din: got %h want 0", din); end
    access(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, lat, err, din, sok, ac);
    n_cmp++; if (din !== 32'h0000_0002) begin n_bad++; $display("FAIL ws0_rd2: got %h want 00000002", din); end
  endtask

  task automatic test_back_to_back();
    int lat, c1, c2; logic err; logic [31:0] din; bit sok;
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'hA0A0_A0A0, lat, err, din, sok, c1);
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, err, din, sok, c2);
    n_cmp++; if (c2 - c1 !== 4) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 4", c2 - c1); end
    n_cmp++; if (din !== 32'hA0A0_A0A0) begin n_bad++; $display("FAIL b2b_din: got %h want a0a0a0a0", din); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_lat: got %0d want 3", lat); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_flush();
    test_reset_mid();
    test_ws0();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
